// File: rtl/e_mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : md_pkg
//  Description : Shared multiply/divide definitions: md_op encodings, FSM
//                state encoding and a class-decode helper. Also used by the
//                instruction decoder and the hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;
   localparam logic [2:0] MD_MFHI  = 3'd6;
   localparam logic [2:0] MD_MFLO  = 3'd7;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   // Multiply and divide ops are the only ones that occupy the unit.
   function automatic logic md_is_arith(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage : md_pkg
`default_nettype wire

// File: rtl/e_mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : e_mul_div_unit_if
//  Description : E-stage request / HI-LO result bundle of the mul/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface e_mul_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       md_op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             busy;
   logic             stall_req;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] md_result;

   modport master (
      output start, md_op, src_a, src_b,
      input  busy, stall_req, hi, lo, md_result
   );

   modport slave (
      input  start, md_op, src_a, src_b,
      output busy, stall_req, hi, lo, md_result
   );
endinterface : e_mul_div_unit_if
`default_nettype wire

// File: rtl/e_mul_div_unit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : md_latency_counter
//  Description : Loadable down-counter that saturates at zero; o_done is
//                high whenever the count has reached zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_latency_counter #(
   parameter int CW = 4
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic          i_load,
   input  wire logic [CW-1:0] i_load_val,
   input  wire logic          i_dec,
   output logic      [CW-1:0] o_value,
   output logic               o_done
);

   logic [CW-1:0] r_value;

   // Load has priority; decrement stops at zero so the count never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_value <= '0;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (i_dec && (r_value != '0)) begin
         r_value <= r_value - 1'b1;
      end
   end

   assign o_value = r_value;
   assign o_done  = (r_value == '0);

endmodule : md_latency_counter
`default_nettype wire

// File: rtl/e_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : e_mul_div_unit
//  Description : Multi-cycle multiply/divide unit with HI/LO registers for
//                the E stage. Results are computed at start, held in
//                hi_nxt/lo_nxt and committed when the latency counter ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module e_mul_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  wire logic        clk,
   input  wire logic        reset,
   e_mul_div_unit_if.slave  md
);

   localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_CW      = $clog2(c_MAX_CYC) + 1;
   localparam logic [c_CW-1:0]  c_MULT_LOAD = c_CW'(MULT_CYCLES - 1);
   localparam logic [c_CW-1:0]  c_DIV_LOAD  = c_CW'(DIV_CYCLES - 1);
   localparam logic [WIDTH-1:0] c_MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};

   md_state_t          r_state;
   logic               r_busy;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_hi_nxt;
   logic [WIDTH-1:0]   r_lo_nxt;

   logic               w_accept;
   logic               w_cnt_load;
   logic [c_CW-1:0]    w_cnt_load_val;
   logic [c_CW-1:0]    w_cnt_value;
   logic               w_cnt_done;

   logic signed [2*WIDTH-1:0] w_prod_s;
   logic        [2*WIDTH-1:0] w_prod_u;
   logic                      w_div_zero;
   logic                      w_div_ovf;
   logic        [WIDTH-1:0]   w_sdiv_b;
   logic        [WIDTH-1:0]   w_udiv_b;
   logic signed [WIDTH-1:0]   w_quot_s;
   logic signed [WIDTH-1:0]   w_rem_s;
   logic        [WIDTH-1:0]   w_quot_u;
   logic        [WIDTH-1:0]   w_rem_u;

   // Widened arithmetic; divisors are steered away from 0 and the
   // MIN_INT/-1 overflow case, whose results are substituted explicitly.
   assign w_prod_s   = $signed({{WIDTH{md.src_a[WIDTH-1]}}, md.src_a})
                     * $signed({{WIDTH{md.src_b[WIDTH-1]}}, md.src_b});
   assign w_prod_u   = {{WIDTH{1'b0}}, md.src_a} * {{WIDTH{1'b0}}, md.src_b};
   assign w_div_zero = (md.src_b == '0);
   assign w_div_ovf  = (md.src_a == c_MIN_INT) && (md.src_b == {WIDTH{1'b1}});
   assign w_sdiv_b   = (w_div_zero || w_div_ovf) ? WIDTH'(1) : md.src_b;
   assign w_udiv_b   = w_div_zero ? WIDTH'(1) : md.src_b;
   assign w_quot_s   = $signed(md.src_a) / $signed(w_sdiv_b);
   assign w_rem_s    = $signed(md.src_a) % $signed(w_sdiv_b);
   assign w_quot_u   = md.src_a / w_udiv_b;
   assign w_rem_u    = md.src_a % w_udiv_b;

   assign w_accept       = (r_state == ST_IDLE) && md.start && md_is_arith(md.md_op);
   assign w_cnt_load     = w_accept;
   assign w_cnt_load_val = md.md_op[1] ? c_DIV_LOAD : c_MULT_LOAD;

   md_latency_counter #(
      .CW (c_CW)
   ) u_lat_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .i_dec      (r_state == ST_RUN),
      .o_value    (w_cnt_value),
      .o_done     (w_cnt_done)
   );

   // Control FSM: latch the result at start, commit HI/LO when the count ends.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_busy   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_hi_nxt <= '0;
         r_lo_nxt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (md.start) begin
                  case (md.md_op)
                     MD_MULT: begin
                        r_hi_nxt <= w_prod_s[2*WIDTH-1:WIDTH];
                        r_lo_nxt <= w_prod_s[WIDTH-1:0];
                     end
                     MD_MULTU: begin
                        r_hi_nxt <= w_prod_u[2*WIDTH-1:WIDTH];
                        r_lo_nxt <= w_prod_u[WIDTH-1:0];
                     end
                     MD_DIV: begin
                        if (w_div_zero) begin
                           r_hi_nxt <= r_hi;
                           r_lo_nxt <= r_lo;
                        end else if (w_div_ovf) begin
                           r_hi_nxt <= '0;
                           r_lo_nxt <= c_MIN_INT;
                        end else begin
                           r_hi_nxt <= w_rem_s;
                           r_lo_nxt <= w_quot_s;
                        end
                     end
                     MD_DIVU: begin
                        if (w_div_zero) begin
                           r_hi_nxt <= r_hi;
                           r_lo_nxt <= r_lo;
                        end else begin
                           r_hi_nxt <= w_rem_u;
                           r_lo_nxt <= w_quot_u;
                        end
                     end
                     MD_MTHI: r_hi <= md.src_a;
                     MD_MTLO: r_lo <= md.src_a;
                     default: ;
                  endcase
                  if (md_is_arith(md.md_op)) begin
                     r_busy  <= 1'b1;
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (w_cnt_done) begin
                  r_hi    <= r_hi_nxt;
                  r_lo    <= r_lo_nxt;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Stall covers the start cycle too, before busy has been registered.
   assign md.stall_req = r_busy || (md.start && md_is_arith(md.md_op));
   assign md.busy      = r_busy;
   assign md.hi        = r_hi;
   assign md.lo        = r_lo;
   assign md.md_result = (md.md_op == MD_MFHI) ? r_hi :
                         (md.md_op == MD_MFLO) ? r_lo : '0;

   logic w_unused;
   assign w_unused = |w_cnt_value;

endmodule : e_mul_div_unit
`default_nettype wire
